// File: rtl/timeset_ctrl.sv
// ---------------------------------------------------------------------------
// timeset_ctrl
//   Time-set control for the watch datapath. A cursor walks over NUM_FIELDS
//   adjustable fields plus IDLE (cursor 0). It is driven by debounced button
//   pulses or by valid-qualified UART command bytes. It supports:
//   - forward and reverse cursor movement
//   - auto-repeat of inc/dec while one of those buttons is held
//   - an inactivity timeout that returns the cursor to IDLE
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   tick              1-cycle timebase strobe
//   btn_move/back/inc/dec/clear
//                     1-cycle debounced command pulses
//   inc_held/dec_held debounced hold levels, used for auto-repeat
//   rx_valid, rx_data UART command byte; the byte is used only while valid
//   field_sel         cursor: 0 = IDLE, k = field k
//   adj_active        high when field_sel != 0
//   inc/dec/clear     1-cycle action pulses to the selected field
//   timeout           1-cycle pulse when inactivity forces IDLE
//
// All outputs are registered. An action seen in cycle N appears in cycle N+1.
// ---------------------------------------------------------------------------
module timeset_ctrl #(
  parameter int         NUM_FIELDS    = 3,
  parameter int         SEL_W         = 2,
  parameter logic [7:0] CMD_MOVE      = 8'h52,
  parameter logic [7:0] CMD_BACK      = 8'h42,
  parameter logic [7:0] CMD_INC       = 8'h55,
  parameter logic [7:0] CMD_DEC       = 8'h44,
  parameter logic [7:0] CMD_CLEAR     = 8'h4C,
  parameter int         REPEAT_DELAY  = 500,
  parameter int         REPEAT_RATE   = 100,
  parameter int         TIMEOUT_TICKS = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_move,
  input  logic             btn_back,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_clear,
  input  logic             inc_held,
  input  logic             dec_held,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [SEL_W-1:0] field_sel,
  output logic             adj_active,
  output logic             inc,
  output logic             dec,
  output logic             clear,
  output logic             timeout
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [SEL_W-1:0] LAST_FIELD = SEL_W'(NUM_FIELDS);
  localparam logic [RPT_W-1:0] DELAY_M1   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_M1    = RPT_W'(REPEAT_RATE - 1);
  localparam logic [TO_W-1:0]  TO_M1      = TO_W'(TIMEOUT_TICKS - 1);

  // Command bit order: 0 move, 1 back, 2 inc, 3 dec, 4 clear.
  // This order is also the priority order.
  localparam logic [4:0][7:0] CMD_CODES = {CMD_CLEAR, CMD_DEC, CMD_INC, CMD_BACK, CMD_MOVE};

  typedef enum logic [2:0] {
    ACT_NONE, ACT_MOVE, ACT_BACK, ACT_INC, ACT_DEC, ACT_CLEAR
  } action_t;

  logic [SEL_W-1:0] field_sel_reg, field_sel_next;
  logic             adj_active_reg;
  logic             inc_reg, inc_next;
  logic             dec_reg, dec_next;
  logic             clear_reg, clear_next;
  logic             timeout_reg, timeout_next;
  logic [RPT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             repeating_reg, repeating_next;
  logic [TO_W-1:0]  idle_cnt_reg, idle_cnt_next;

  logic [4:0] btn_vec;
  logic [4:0] cmd_vec;
  action_t    action;
  logic       sel_illegal;
  logic       repeat_fire;
  logic       expire;

  assign btn_vec = {btn_clear, btn_dec, btn_inc, btn_back, btn_move};

  // A command comes from its button pulse or from a matching valid byte.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_cmd
      assign cmd_vec[gi] = btn_vec[gi] | (rx_valid && (rx_data == CMD_CODES[gi]));
    end
  endgenerate

  // An illegal cursor value can only occur when the select width
  // leaves unused codes.
  generate
    if ((2 ** SEL_W) - 1 > NUM_FIELDS) begin : g_illegal
      assign sel_illegal = (field_sel_reg > LAST_FIELD);
    end else begin : g_no_illegal
      assign sel_illegal = 1'b0;
    end
  endgenerate

  always_comb begin
    action = ACT_NONE;
    if (cmd_vec[0])      action = ACT_MOVE;
    else if (cmd_vec[1]) action = ACT_BACK;
    else if (cmd_vec[2]) action = ACT_INC;
    else if (cmd_vec[3]) action = ACT_DEC;
    else if (cmd_vec[4]) action = ACT_CLEAR;
  end

  always_comb begin
    field_sel_next = field_sel_reg;
    inc_next       = 1'b0;
    dec_next       = 1'b0;
    clear_next     = 1'b0;
    timeout_next   = 1'b0;
    hold_cnt_next  = hold_cnt_reg;
    repeating_next = repeating_reg;
    idle_cnt_next  = idle_cnt_reg;
    repeat_fire    = 1'b0;
    expire         = 1'b0;

    if (sel_illegal) begin
      field_sel_next = '0;
      hold_cnt_next  = '0;
      repeating_next = 1'b0;
      idle_cnt_next  = '0;
    end else if (field_sel_reg == '0) begin
      hold_cnt_next  = '0;
      repeating_next = 1'b0;
      idle_cnt_next  = '0;
      case (action)
        ACT_MOVE:  field_sel_next = SEL_W'(1);
        ACT_BACK:  field_sel_next = LAST_FIELD;
        ACT_CLEAR: clear_next     = 1'b1;
        default:   ;
      endcase
    end else begin
      // Auto-repeat. The counter restarts after every pulse. The first
      // pulse uses REPEAT_DELAY as its target; later pulses use REPEAT_RATE.
      if (inc_held == dec_held) begin
        hold_cnt_next  = '0;
        repeating_next = 1'b0;
      end else if (tick) begin
        if (hold_cnt_reg >= (repeating_reg ? RATE_M1 : DELAY_M1)) begin
          hold_cnt_next  = '0;
          repeating_next = 1'b1;
          repeat_fire    = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + RPT_W'(1);
        end
      end

      if (tick) begin
        if (idle_cnt_reg >= TO_M1) expire = 1'b1;
        else                       idle_cnt_next = idle_cnt_reg + TO_W'(1);
      end

      // An explicit action outranks both a repeat pulse and an expiry.
      // The hold counter keeps its timing when its pulse is dropped.
      case (action)
        ACT_MOVE: begin
          field_sel_next = (field_sel_reg == LAST_FIELD) ? '0 : field_sel_reg + SEL_W'(1);
          hold_cnt_next  = '0;
          repeating_next = 1'b0;
          idle_cnt_next  = '0;
        end
        ACT_BACK: begin
          field_sel_next = field_sel_reg - SEL_W'(1);
          hold_cnt_next  = '0;
          repeating_next = 1'b0;
          idle_cnt_next  = '0;
        end
        ACT_INC: begin
          inc_next      = 1'b1;
          idle_cnt_next = '0;
        end
        ACT_DEC: begin
          dec_next      = 1'b1;
          idle_cnt_next = '0;
        end
        ACT_CLEAR: begin
          clear_next    = 1'b1;
          idle_cnt_next = '0;
        end
        default: begin
          if (repeat_fire) begin
            inc_next      = inc_held;
            dec_next      = dec_held;
            idle_cnt_next = '0;
          end else if (expire) begin
            field_sel_next = '0;
            timeout_next   = 1'b1;
            idle_cnt_next  = '0;
            hold_cnt_next  = '0;
            repeating_next = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_sel_reg  <= '0;
      adj_active_reg <= 1'b0;
      inc_reg        <= 1'b0;
      dec_reg        <= 1'b0;
      clear_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
      hold_cnt_reg   <= '0;
      repeating_reg  <= 1'b0;
      idle_cnt_reg   <= '0;
    end else begin
      field_sel_reg  <= field_sel_next;
      adj_active_reg <= (field_sel_next != '0);
      inc_reg        <= inc_next;
      dec_reg        <= dec_next;
      clear_reg      <= clear_next;
      timeout_reg    <= timeout_next;
      hold_cnt_reg   <= hold_cnt_next;
      repeating_reg  <= repeating_next;
      idle_cnt_reg   <= idle_cnt_next;
    end
  end

  assign field_sel  = field_sel_reg;
  assign adj_active = adj_active_reg;
  assign inc        = inc_reg;
  assign dec        = dec_reg;
  assign clear      = clear_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_timeset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timeset_ctrl
//   Self-checking bench for timeset_ctrl. It is built with NUM_FIELDS=3,
//   REPEAT_DELAY=4, REPEAT_RATE=2 and TIMEOUT_TICKS=10.
//
//   The reference model is written in terms of the behavioural rules:
//   - a cursor number
//   - a running count of ticks held
//   - a running count of idle ticks
//
//   The bench first runs directed scenarios, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_timeset_ctrl;

  localparam int NF = 3;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam int TT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, btn_move, btn_back, btn_inc, btn_dec, btn_clear;
  logic       inc_held, dec_held, rx_valid;
  logic [7:0] rx_data;
  logic [1:0] field_sel;
  logic       adj_active, inc, dec, clear, timeout;

  timeset_ctrl #(
    .NUM_FIELDS(NF), .SEL_W(2), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_move(btn_move), .btn_back(btn_back), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_clear(btn_clear),
    .inc_held(inc_held), .dec_held(dec_held),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .field_sel(field_sel), .adj_active(adj_active),
    .inc(inc), .dec(dec), .clear(clear), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_cur, m_held_ticks, m_idle_ticks;
  int e_inc, e_dec, e_clr, e_to;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_held_ticks = 0; m_idle_ticks = 0;
    e_inc = 0; e_dec = 0; e_clr = 0; e_to = 0;
  endtask

  // Predict the outputs that appear after the next rising edge,
  // given the inputs currently driven.
  task automatic model_step();
    bit mv, bk, ic, dc, cl, fire, expire;
    mv = btn_move  || (rx_valid && rx_data == 8'h52);
    bk = btn_back  || (rx_valid && rx_data == 8'h42);
    ic = btn_inc   || (rx_valid && rx_data == 8'h55);
    dc = btn_dec   || (rx_valid && rx_data == 8'h44);
    cl = btn_clear || (rx_valid && rx_data == 8'h4C);
    e_inc = 0; e_dec = 0; e_clr = 0; e_to = 0;
    if (m_cur == 0) begin
      m_held_ticks = 0;
      m_idle_ticks = 0;
      if (mv)      m_cur = 1;
      else if (bk) m_cur = NF;
      else if (!ic && !dc && cl) e_clr = 1;
    end else begin
      fire = 0;
      expire = 0;
      if (inc_held != dec_held) begin
        if (tick) begin
          m_held_ticks++;
          fire = (m_held_ticks == RD) ||
                 (m_held_ticks > RD && ((m_held_ticks - RD) % RR) == 0);
        end
      end else begin
        m_held_ticks = 0;
      end
      if (tick) begin
        m_idle_ticks++;
        if (m_idle_ticks >= TT) expire = 1;
      end
      if (mv) begin
        m_cur = (m_cur == NF) ? 0 : m_cur + 1;
        m_held_ticks = 0;
        m_idle_ticks = 0;
      end else if (bk) begin
        m_cur = m_cur - 1;
        m_held_ticks = 0;
        m_idle_ticks = 0;
      end else if (ic) begin
        e_inc = 1; m_idle_ticks = 0;
      end else if (dc) begin
        e_dec = 1; m_idle_ticks = 0;
      end else if (cl) begin
        e_clr = 1; m_idle_ticks = 0;
      end else if (fire) begin
        e_inc = inc_held ? 1 : 0;
        e_dec = dec_held ? 1 : 0;
        m_idle_ticks = 0;
      end else if (expire) begin
        m_cur = 0; e_to = 1; m_idle_ticks = 0; m_held_ticks = 0;
      end
    end
  endtask

  // Drive inputs before calling this task.
  // The task applies one clock edge and checks every output.
  // It then clears the pulse inputs; held levels persist.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".sel"},  int'(field_sel), m_cur);
    check({tag, ".adj"},  int'(adj_active), (m_cur != 0) ? 1 : 0);
    check({tag, ".inc"},  int'(inc), e_inc);
    check({tag, ".dec"},  int'(dec), e_dec);
    check({tag, ".clr"},  int'(clear), e_clr);
    check({tag, ".to"},   int'(timeout), e_to);
    @(negedge clk);
    tick = 0; btn_move = 0; btn_back = 0; btn_inc = 0; btn_dec = 0; btn_clear = 0;
    rx_valid = 0;
  endtask

  task automatic go_field(input int target);
    for (int i = 0; i < 8 && int'(field_sel) != target; i++) begin
      btn_move = 1;
      step("nav");
    end
    check("nav.reach", int'(field_sel), target);
  endtask

  initial begin : main
    int seq [4];
    int act_pct;
    logic [7:0] codes [6];
    seq = '{1, 2, 3, 0};
    codes = '{8'h52, 8'h42, 8'h55, 8'h44, 8'h4C, 8'h00};

    tick = 0; btn_move = 0; btn_back = 0; btn_inc = 0; btn_dec = 0; btn_clear = 0;
    inc_held = 0; dec_held = 0; rx_valid = 0; rx_data = 8'h00;
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst.sel", int'(field_sel), 0);
    check("rst.adj", int'(adj_active), 0);
    check("rst.pulses", int'({inc, dec, clear, timeout}), 0);
    rst = 0;
    model_reset();
    $display("txn reset released: field_sel=%0d", field_sel);

    // Forward walk with wrap, then reverse out of IDLE.
    for (int i = 0; i < 4; i++) begin
      btn_move = 1;
      step("move");
      check("move.seq", int'(field_sel), seq[i]);
      $display("txn move %0d: field_sel=%0d", i, field_sel);
    end
    btn_back = 1;
    step("back");
    check("back.idle", int'(field_sel), 3);
    $display("txn back from idle: field_sel=%0d", field_sel);
    btn_move = 1;
    step("wrap");

    // A UART byte counts only when rx_valid is high.
    rx_valid = 0; rx_data = 8'h52;
    step("rx_inval");
    check("rx_inval.sel", int'(field_sel), 0);
    rx_valid = 1; rx_data = 8'h52;
    step("rx_val");
    check("rx_val.sel", int'(field_sel), 1);
    $display("txn uart move: field_sel=%0d", field_sel);

    // Priority between simultaneous commands.
    go_field(2);
    btn_inc = 1; rx_valid = 1; rx_data = 8'h44;
    step("prio_id");
    check("prio_id.inc", int'(inc), 1);
    check("prio_id.dec", int'(dec), 0);
    btn_move = 1; btn_inc = 1;
    step("prio_mi");
    check("prio_mi.sel", int'(field_sel), 3);
    check("prio_mi.inc", int'(inc), 0);
    $display("txn priority: field_sel=%0d inc=%0d", field_sel, inc);

    // Auto-repeat on a held inc; holding both stops it.
    go_field(1);
    inc_held = 1;
    for (int t = 1; t <= 10; t++) begin
      tick = 1;
      step("rpt");
      check("rpt.pulse", int'(inc), (t == 4 || t == 6 || t == 8 || t == 10) ? 1 : 0);
      $display("txn repeat tick %0d: inc=%0d", t, inc);
    end
    dec_held = 1;
    for (int t = 1; t <= 4; t++) begin
      tick = 1;
      step("both");
      check("both.none", int'({inc, dec}), 0);
    end
    inc_held = 0; dec_held = 0;

    // Inactivity timeout. A move resets the idle count.
    go_field(2);
    for (int t = 1; t <= TT; t++) begin
      tick = 1;
      step("to");
      check("to.pulse", int'(timeout), (t == TT) ? 1 : 0);
    end
    check("to.sel", int'(field_sel), 0);
    step("to_after");
    check("to_after.pulse", int'(timeout), 0);
    $display("txn timeout: field_sel=%0d", field_sel);

    // An action on the 9th tick restarts the idle count.
    go_field(2);
    for (int t = 1; t <= 8; t++) begin
      tick = 1;
      step("to9");
    end
    tick = 1; btn_inc = 1;
    step("to9_act");
    for (int t = 1; t <= TT; t++) begin
      tick = 1;
      step("to_rs");
      check("to_rs.pulse", int'(timeout), (t == TT) ? 1 : 0);
    end
    $display("txn timeout restart: field_sel=%0d", field_sel);

    // Reset in the middle of an auto-repeat sequence.
    go_field(1);
    inc_held = 1;
    for (int t = 1; t <= 4; t++) begin
      tick = 1;
      step("rr");
    end
    check("rr.pre", int'(inc), 1);
    rst = 1;
    #1;
    check("rr.async_inc", int'(inc), 0);
    check("rr.async_sel", int'(field_sel), 0);
    check("rr.async_adj", int'(adj_active), 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int t = 1; t <= 6; t++) begin
      tick = 1;
      step("rr_post");
      check("rr_post.inc", int'(inc), 0);
    end
    inc_held = 0;
    $display("txn reset mid-repeat: inc=%0d field_sel=%0d", inc, field_sel);

    // Randomized traffic against the model.
    act_pct = 10;
    for (int c = 0; c < 600; c++) begin
      if (c % 75 == 0) act_pct = (($urandom_range(0, 2) == 0) ? 1 : ($urandom_range(0, 1) ? 8 : 30));
      tick      = ($urandom_range(0, 2) == 0);
      btn_move  = ($urandom_range(0, 199) < act_pct);
      btn_back  = ($urandom_range(0, 199) < act_pct);
      btn_inc   = ($urandom_range(0, 199) < act_pct);
      btn_dec   = ($urandom_range(0, 199) < act_pct);
      btn_clear = ($urandom_range(0, 199) < act_pct);
      rx_valid  = ($urandom_range(0, 99) < act_pct);
      rx_data   = codes[$urandom_range(0, 5)];
      if (rx_data == 8'h00) rx_data = 8'($urandom);
      if ($urandom_range(0, 19) == 0) inc_held = ~inc_held;
      if ($urandom_range(0, 19) == 0) dec_held = ~dec_held;
      step("rnd");
      $display("txn rnd %0d: sel=%0d inc=%0d dec=%0d clr=%0d to=%0d", c, field_sel, inc, dec, clear, timeout);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Upper bound on run time.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
